// File: rtl/ifetch_ctrl_pkg.sv
// Shared CPU fetch definitions: default widths, word step and fetch FSM states.
package ifetch_ctrl_pkg;

  localparam int unsigned IF_ADDR_W  = 12;
  localparam int unsigned IF_DATA_W  = 32;
  localparam int unsigned IF_PC_STEP = 4;

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } if_state_e;

endpackage

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: walks the PC through an external instruction
// memory and presents one registered instruction at a time to the consumer.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_W   = IF_ADDR_W,
  parameter int unsigned           DATA_W   = IF_DATA_W,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_data,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  input  logic              resume,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [15:0]       fetch_cnt
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              capture;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;
    capture = (state_q == ST_FETCH) && !br_valid && !halt && (!valid_q || out_ready);

    // A redirect flushes the output slot and overrides both capture and consume.
    if (br_valid) begin
      pc_d    = {br_target[ADDR_W-1:2], 2'b00};
      valid_d = 1'b0;
    end else if (capture) begin
      instr_d = im_data;
      opc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + ADDR_W'(IF_PC_STEP);
      cnt_d   = cnt_q + 16'd1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (halt) begin
      state_d = ST_HALTED;
    end else if ((state_q == ST_HALTED) && resume) begin
      state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign im_addr   = pc_q;
  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = opc_q;
  assign halted    = (state_q == ST_HALTED);
  assign fetch_cnt = cnt_q;

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, is the byte-address width of the instruction memory.
REQ-002 Parameter DATA_W, default 32, is the instruction word width.
REQ-003 Parameter RESET_PC, default 0, is the first fetch address after reset; it SHALL be word-aligned.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port im_addr, output, ADDR_W bits: byte address to the instruction memory, driven directly from the PC register.
REQ-007 Port im_data, input, DATA_W bits: instruction memory read data, combinational from im_addr.
REQ-008 Port br_valid, input, 1 bit: redirect request.
REQ-009 Port br_target, input, ADDR_W bits: redirect byte address.
REQ-010 Port halt, input, 1 bit: stop-fetch request.
REQ-011 Port resume, input, 1 bit: restart-fetch request.
REQ-012 Port out_valid, output, 1 bit: out_instr/out_pc hold a valid fetched instruction.
REQ-013 Port out_ready, input, 1 bit: the consumer accepts the instruction this cycle.
REQ-014 Port out_instr, output, DATA_W bits: registered instruction word.
REQ-015 Port out_pc, output, ADDR_W bits: byte address of out_instr.
REQ-016 Port halted, output, 1 bit: high while the FSM is in HALTED.
REQ-017 Port fetch_cnt, output, 16 bits: count of instructions captured since reset.

Function
REQ-018 The FSM SHALL have two states: FETCH and HALTED.
REQ-019 Capture is enabled when the state is FETCH, br_valid=0, and (out_valid=0 or out_ready=1).
REQ-020 On capture, out_instr<=im_data, out_pc<=pc, out_valid<=1, pc<=pc+4, and fetch_cnt<=fetch_cnt+1 are applied, with one cycle of latency from im_addr to out_valid.
REQ-021 PC increment SHALL wrap modulo 2^ADDR_W, so 0xFFC+4 becomes 0x000 with no flag.
REQ-022 When out_valid=1 and out_ready=0, out_instr, out_pc, and pc SHALL hold stable.
REQ-023 When out_valid=1, out_ready=1, and capture is disabled, out_valid<=0.
REQ-024 br_valid=1 in either state: pc<=br_target with bits [1:0] forced to 0, out_valid<=0, no capture, fetch_cnt unchanged.
REQ-025 br_valid has priority over capture and over out_ready in the same cycle; the instruction held that cycle is discarded.
REQ-026 halt=1 in FETCH moves the FSM to HALTED next cycle with no capture that cycle; a held out_valid SHALL remain until consumed.
REQ-027 resume=1 in HALTED moves the FSM to FETCH; the first capture occurs the cycle after.
REQ-028 halt=1 and resume=1 together: halt wins, and the FSM enters or stays in HALTED.
REQ-029 halt and br_valid together: both take effect (PC redirected, slot flushed, HALTED entered).
REQ-030 fetch_cnt SHALL wrap at 0xFFFF to 0x0000.

Reset
REQ-031 While rst_n=0: pc=RESET_PC, state=FETCH, out_valid=0, out_instr=0, out_pc=0, fetch_cnt=0, halted=0.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL discard all pending state immediately, without waiting for a clock edge.
REQ-033 After rst_n deasserts, the first capture of address RESET_PC SHALL occur on the first rising edge.

Structure
REQ-034 FSM state encoding, ADDR_W/DATA_W defaults, and the +4 word-step constant SHALL live in a shared CPU package.
REQ-035 The block SHALL be a single module with no sub-module; the instruction memory is instantiated externally and connected by im_addr/im_data.

Verification
REQ-036 Reset, then out_ready=1 held with IM preloaded so word k = k: out_pc sequence 0x000,0x004,0x008; out_instr 0,1,2; fetch_cnt 3 after three edges.
REQ-037 out_ready=0 for 4 cycles at out_pc=0x008: out_instr/out_pc/im_addr constant at 0x008/0x00C; fetching resumes in order on out_ready=1.
REQ-038 br_valid=1, br_target=0x123 while out_valid=1: next cycle out_valid=0 and im_addr=0x120; following capture gives out_pc=0x120.
REQ-039 Start at pc=0xFF8 with out_ready=1: out_pc 0xFF8, 0xFFC, then 0x000.
REQ-040 halt pulse: halted=1 next cycle and no new capture for 5 cycles; resume pulse then yields the next sequential out_pc; halt+resume in the same cycle keeps halted=1.
REQ-041 Assert rst_n=0 asynchronously mid-stall: out_valid and fetch_cnt drop to 0 before the next edge, and im_addr=RESET_PC.
